// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus the decoder-side
// valid/ready instruction stream and jump feedback.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_en;
  logic [31:0] jump_addr;

  modport master (
    output imem_req, imem_addr, instruction, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, jump_en, jump_addr
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready, jump_en, jump_addr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: PC ownership, 2-entry prefetch queue, jump redirect/flush.
// Optional macro FETCH_PERF_CNT_EN adds a delivered-instruction counter output.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_fetch_unit_if.master     bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_instr_cnt
`endif
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t      state_reg;
  logic [31:0] fetch_pc_reg;
  logic [31:0] redirect_pc_reg;
  logic [1:0]  count_reg;
  logic        req_reg;
  logic [31:0] q_instr_reg [2];
  logic [31:0] q_pc_reg    [2];

  logic        pop;
  logic        push;
  logic        jump;
  logic        wr_idx;
  logic [31:0] target;
  logic [1:0]  count_next;

  assign bus.imem_req    = req_reg;
  assign bus.imem_addr   = fetch_pc_reg;
  assign bus.instruction = q_instr_reg[0];
  assign bus.instr_pc    = q_pc_reg[0];
  assign bus.instr_valid = (count_reg != 2'd0);

  always_comb begin
    pop        = bus.instr_valid & bus.instr_ready;
    push       = (state_reg == RUN) & req_reg & bus.imem_ack;
    jump       = pop & bus.jump_en;
    target     = q_pc_reg[0] + 32'd1 + bus.jump_addr;
    // A push only happens below capacity, so with a pop the slot is always 0
    wr_idx     = pop ? 1'b0 : count_reg[0];
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Queue storage needs no reset: count_reg alone decides what is live
  always_ff @(posedge clk) begin
    if (pop) begin
      q_instr_reg[0] <= q_instr_reg[1];
      q_pc_reg[0]    <= q_pc_reg[1];
    end
    if (push) begin
      q_instr_reg[wr_idx] <= bus.imem_rdata;
      q_pc_reg[wr_idx]    <= fetch_pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      fetch_pc_reg    <= RESET_PC;
      redirect_pc_reg <= RESET_PC;
      count_reg       <= 2'd0;
      req_reg         <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (jump) begin
            count_reg <= 2'd0;
            req_reg   <= 1'b1;
            // An unanswered request must complete before the target can be issued
            if (req_reg && !bus.imem_ack) begin
              redirect_pc_reg <= target;
              state_reg       <= DRAIN;
            end else begin
              fetch_pc_reg <= target;
            end
          end else begin
            count_reg <= count_next;
            req_reg   <= (count_next != 2'd2);
            if (push) begin
              fetch_pc_reg <= fetch_pc_reg + 32'd1;
            end
          end
        end
        DRAIN: begin
          req_reg <= 1'b1;
          if (bus.imem_ack) begin
            fetch_pc_reg <= redirect_pc_reg;
            state_reg    <= RUN;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_reg <= 32'd0;
    end else if (pop) begin
      perf_cnt_reg <= perf_cnt_reg + 32'd1;
    end
  end

  assign perf_instr_cnt = perf_cnt_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming/stall vector table, then
// hand sequences for jumps, wrap-around, the drain path and reset in drain.
module tb_instr_fetch_unit;

  localparam logic [31:0] DATA_KEY = 32'hC0DE_0000;

  logic clk;
  logic rst;
  logic ack_en;
  int   n_cmp;
  int   n_bad;
  logic found;

  instr_fetch_unit_if bus();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf;
`endif

  instr_fetch_unit #(.RESET_PC(32'h0000_0010)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_instr_cnt (perf)
`endif
  );

  // Memory model: answers in the same cycle whenever ack_en allows it
  assign bus.imem_ack   = ack_en & bus.imem_req;
  assign bus.imem_rdata = bus.imem_addr ^ DATA_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic req, input logic [31:0] addr,
                            input logic valid, input logic [31:0] pc);
    $display("%s: req=%b addr=%h valid=%b pc=%h instr=%h", nm, bus.imem_req,
             bus.imem_addr, bus.instr_valid, bus.instr_pc, bus.instruction);
    chk({nm, ".req"}, 32'(bus.imem_req), 32'(req));
    if (req) chk({nm, ".addr"}, bus.imem_addr, addr);
    chk({nm, ".valid"}, 32'(bus.instr_valid), 32'(valid));
    if (valid) begin
      chk({nm, ".pc"}, bus.instr_pc, pc);
      chk({nm, ".instr"}, bus.instruction, pc ^ DATA_KEY);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    found = 1'b0;

    // Stall for 5 cycles from the first fetch, then stream
    vecs[0]  = '{1'b0, 1'b1, 32'h10, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 32'h11, 1'b1, 32'h10};
    vecs[2]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    vecs[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    vecs[5]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
    vecs[6]  = '{1'b1, 1'b1, 32'h12, 1'b1, 32'h11};
    vecs[7]  = '{1'b1, 1'b1, 32'h13, 1'b1, 32'h12};
    vecs[8]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h13};
    vecs[9]  = '{1'b1, 1'b1, 32'h15, 1'b1, 32'h14};
    vecs[10] = '{1'b1, 1'b1, 32'h16, 1'b1, 32'h15};

    rst = 1'b1;
    ack_en = 1'b1;
    bus.instr_ready = 1'b0;
    bus.jump_en = 1'b0;
    bus.jump_addr = 32'h0;
    repeat (3) tick();
    expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_reset", perf, 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                 vecs[i].exp_valid, vecs[i].exp_pc);
      bus.instr_ready = vecs[i].ready;
    end

    // Stream until pc 0x20 reaches the head
    for (int i = 0; i < 64; i++) begin
      tick();
      if (bus.instr_valid && bus.instr_pc == 32'h20) begin
        found = 1'b1;
        break;
      end
    end
    chk("find_pc20", 32'(found), 32'd1);

    // Jump +5 with the ack of 0x21 in the same cycle
    expect_out("jmp_pre", 1'b1, 32'h21, 1'b1, 32'h20);
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'h5;
    tick(); expect_out("jmp_tgt", 1'b1, 32'h26, 1'b0, 32'h0);
    bus.jump_en = 1'b0;
    tick(); expect_out("jmp_head", 1'b1, 32'h27, 1'b1, 32'h26);
    tick(); expect_out("jmp_next", 1'b1, 32'h28, 1'b1, 32'h27);

    // Jump to the top of the address space, then wrap with offset 0
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'hFFFF_FFD7;
    tick(); expect_out("to_max", 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    bus.jump_en = 1'b0;
    tick(); expect_out("at_max", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFF);
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'h0;
    tick(); expect_out("wrap_tgt", 1'b1, 32'h0, 1'b0, 32'h0);
    bus.jump_en = 1'b0;
    tick(); expect_out("wrap_head", 1'b1, 32'h1, 1'b1, 32'h0);

    // Back to 0x20, then jump -2 while the request to 0x21 stalls
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'h1F;
    tick(); expect_out("to_20", 1'b1, 32'h20, 1'b0, 32'h0);
    bus.jump_en = 1'b0;
    tick(); expect_out("drain_pre", 1'b1, 32'h21, 1'b1, 32'h20);
    ack_en = 1'b0;
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'hFFFF_FFFE;
    tick(); expect_out("drain0", 1'b1, 32'h21, 1'b0, 32'h0);
    bus.jump_en = 1'b0;
    tick(); expect_out("drain1", 1'b1, 32'h21, 1'b0, 32'h0);
    tick(); expect_out("drain2", 1'b1, 32'h21, 1'b0, 32'h0);
    ack_en = 1'b1;
    tick(); expect_out("drain_tgt", 1'b1, 32'h1F, 1'b0, 32'h0);
    tick(); expect_out("drain_head", 1'b1, 32'h20, 1'b1, 32'h1F);

    // Enter DRAIN again and reset there
    ack_en = 1'b0;
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'h0;
    tick(); expect_out("drain_b", 1'b1, 32'h20, 1'b0, 32'h0);
    bus.jump_en = 1'b0;
    rst = 1'b1;
    tick(); expect_out("rst_drain", 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_after_rst", perf, 32'd0);
`endif
    rst = 1'b0;
    ack_en = 1'b1;
    tick(); expect_out("restart", 1'b1, 32'h10, 1'b0, 32'h0);
    tick(); expect_out("restart_head", 1'b1, 32'h11, 1'b1, 32'h10);
    tick(); expect_out("restart_next", 1'b1, 32'h12, 1'b1, 32'h11);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_count", perf, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
